// File: rtl/keypad_pkg.sv
// keypad_pkg
//   Definitions shared by the keypad scanner and its tick generator.
//   - state_e / ST_* : scanner FSM state encoding (SCAN, DEBOUNCE, HELD)
//   - KEY_IDLE       : active-low "no key" pattern on c/r and rows
//   - COL_FIRST      : first column strobe of the scan sequence
//   - next_col()     : column rotation 1110 -> 1101 -> 1011 -> 0111 -> 1110
//   - single_low()   : true when exactly one bit of a 4-bit vector is low
//   - onehot_low_to_idx() : active-low one-hot to 2-bit index
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2
    } state_e;

    localparam logic [1:0] ST_SCAN     = SCAN;
    localparam logic [1:0] ST_DEBOUNCE = DEBOUNCE;
    localparam logic [1:0] ST_HELD     = HELD;

    localparam logic [3:0] KEY_IDLE  = 4'b1111;
    localparam logic [3:0] COL_FIRST = 4'b1110;

    // Any non-legal column pattern falls back to the first column so the
    // scan can never get stuck on a corrupted strobe value.
    function automatic logic [3:0] next_col(input logic [3:0] col);
        case (col)
            4'b1110: next_col = 4'b1101;
            4'b1101: next_col = 4'b1011;
            4'b1011: next_col = 4'b0111;
            default: next_col = 4'b1110;
        endcase
    endfunction

    function automatic logic single_low(input logic [3:0] v);
        case (v)
            4'b1110, 4'b1101, 4'b1011, 4'b0111: single_low = 1'b1;
            default:                            single_low = 1'b0;
        endcase
    endfunction

    function automatic logic [1:0] onehot_low_to_idx(input logic [3:0] v);
        case (v)
            4'b1101: onehot_low_to_idx = 2'd1;
            4'b1011: onehot_low_to_idx = 2'd2;
            4'b0111: onehot_low_to_idx = 2'd3;
            default: onehot_low_to_idx = 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// keypad_scanner_if
//   Key hand-off from the keypad scanner to the vending-machine FSM.
//   - c         : accepted key column, active-low one-hot, 1111 = no key
//   - r         : accepted key row, active-low one-hot, 1111 = no key
//   - key_valid : one-cycle strobe when a press is accepted
//   - key_code  : {col_idx, row_idx}
//   master = scanner side (drives), slave = FSM side (observes).
interface keypad_scanner_if;
    logic [3:0] c;
    logic [3:0] r;
    logic       key_valid;
    logic [3:0] key_code;

    modport master (output c, output r, output key_valid, output key_code);
    modport slave  (input  c, input  r, input  key_valid, input  key_code);
endinterface

// File: rtl/keypad_tick_gen.sv
// keypad_tick_gen
//   Free-running divider producing the scan tick (column dwell period).
//   - clk   : system clock
//   - reset : asynchronous, active-low
//   - tick  : high for one cycle when the count equals SCAN_DIV-1
module keypad_tick_gen #(
    parameter int SCAN_DIV = 50000
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);
    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);

    logic [CW-1:0] cnt_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            cnt_reg <= '0;
        else if (cnt_reg == CNT_LAST)
            cnt_reg <= '0;
        else
            cnt_reg <= cnt_reg + 1'b1;
    end

    assign tick = (cnt_reg == CNT_LAST);
endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner
//   Scans a 4x4 active-low matrix keypad, debounces presses and releases,
//   and hands each accepted key to the FSM as a held c/r level plus a
//   one-cycle key_valid strobe and a binary key_code.
//   - clk       : system clock
//   - reset     : asynchronous, active-low
//   - row_in    : raw rows, active-low, asynchronous to clk
//   - col_drive : column strobes, active-low one-hot
//   - key_if    : c / r / key_valid / key_code towards the FSM
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV     = 50000,
    parameter int DEBOUNCE_CNT = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       row_in,
    output logic [3:0]       col_drive,
    keypad_scanner_if.master key_if
);
    localparam int DW = $clog2(DEBOUNCE_CNT + 1);
    localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_CNT);

    logic       tick;
    logic [3:0] sync1_reg, sync2_reg;
    logic [3:0] rs;

    logic [1:0]    state_reg,   state_next;
    logic [3:0]    col_reg,     col_next;
    logic [3:0]    cap_col_reg, cap_col_next;
    logic [3:0]    cap_row_reg, cap_row_next;
    logic [DW-1:0] deb_cnt_reg, deb_cnt_next;
    logic [DW-1:0] rel_cnt_reg, rel_cnt_next;
    logic [3:0]    c_reg,       c_next;
    logic [3:0]    r_reg,       r_next;
    logic          valid_reg,   valid_next;
    logic [3:0]    code_reg,    code_next;
    logic [DW-1:0] deb_inc, rel_inc;

    keypad_tick_gen #(.SCAN_DIV(SCAN_DIV)) u_tick_gen (
        .clk   (clk),
        .reset (reset),
        .tick  (tick)
    );

    // Rows idle high, so the synchronizer resets to 1111 to avoid a
    // phantom press right after reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_reg <= KEY_IDLE;
            sync2_reg <= KEY_IDLE;
        end else begin
            sync1_reg <= row_in;
            sync2_reg <= sync1_reg;
        end
    end
    assign rs = sync2_reg;

    assign deb_inc = deb_cnt_reg + DW'(1);
    assign rel_inc = rel_cnt_reg + DW'(1);

    always_comb begin
        state_next   = state_reg;
        col_next     = col_reg;
        cap_col_next = cap_col_reg;
        cap_row_next = cap_row_reg;
        deb_cnt_next = deb_cnt_reg;
        rel_cnt_next = rel_cnt_reg;
        c_next       = c_reg;
        r_next       = r_reg;
        code_next    = code_reg;
        valid_next   = 1'b0;

        if (tick) begin
            case (state_reg)
                ST_SCAN: begin
                    // Multiple low rows on one column are ghost/double
                    // presses and are skipped like an idle column.
                    if (single_low(rs)) begin
                        cap_col_next = col_reg;
                        cap_row_next = rs;
                        deb_cnt_next = DW'(1);
                        state_next   = ST_DEBOUNCE;
                    end else begin
                        col_next = next_col(col_reg);
                    end
                end
                ST_DEBOUNCE: begin
                    if (rs == cap_row_reg) begin
                        deb_cnt_next = deb_inc;
                        if (deb_inc == DEB_LAST) begin
                            state_next   = ST_HELD;
                            c_next       = cap_col_reg;
                            r_next       = cap_row_reg;
                            code_next    = {onehot_low_to_idx(cap_col_reg),
                                            onehot_low_to_idx(cap_row_reg)};
                            valid_next   = 1'b1;
                            rel_cnt_next = '0;
                        end
                    end else begin
                        state_next = ST_SCAN;
                        col_next   = next_col(col_reg);
                    end
                end
                ST_HELD: begin
                    // Column stays frozen here, so any non-idle row (even a
                    // second key on this column) restarts the release count.
                    if (rs == KEY_IDLE) begin
                        if (rel_inc == DEB_LAST) begin
                            rel_cnt_next = '0;
                            c_next       = KEY_IDLE;
                            r_next       = KEY_IDLE;
                            col_next     = COL_FIRST;
                            state_next   = ST_SCAN;
                        end else begin
                            rel_cnt_next = rel_inc;
                        end
                    end else begin
                        rel_cnt_next = '0;
                    end
                end
                default: begin
                    state_next = ST_SCAN;
                    col_next   = COL_FIRST;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg   <= ST_SCAN;
            col_reg     <= COL_FIRST;
            cap_col_reg <= KEY_IDLE;
            cap_row_reg <= KEY_IDLE;
            deb_cnt_reg <= '0;
            rel_cnt_reg <= '0;
            c_reg       <= KEY_IDLE;
            r_reg       <= KEY_IDLE;
            valid_reg   <= 1'b0;
            code_reg    <= '0;
        end else begin
            state_reg   <= state_next;
            col_reg     <= col_next;
            cap_col_reg <= cap_col_next;
            cap_row_reg <= cap_row_next;
            deb_cnt_reg <= deb_cnt_next;
            rel_cnt_reg <= rel_cnt_next;
            c_reg       <= c_next;
            r_reg       <= r_next;
            valid_reg   <= valid_next;
            code_reg    <= code_next;
        end
    end

    assign col_drive        = col_reg;
    assign key_if.c         = c_reg;
    assign key_if.r         = r_reg;
    assign key_if.key_valid = valid_reg;
    assign key_if.key_code  = code_reg;
endmodule

// File: tb/tb_keypad_scanner.sv
`timescale 1ns/1ps
module tb_keypad_scanner;
    localparam int SCAN_DIV     = 4;
    localparam int DEBOUNCE_CNT = 3;
    localparam int REL_MAX      = 2 + DEBOUNCE_CNT * SCAN_DIV;

    typedef struct packed {
        logic [3:0] c;
        logic [3:0] r;
        logic [3:0] code;
    } exp_t;

    logic       clk   = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] row_in;
    logic [3:0] col_drive;

    keypad_scanner_if key_if ();

    keypad_scanner #(
        .SCAN_DIV     (SCAN_DIV),
        .DEBOUNCE_CNT (DEBOUNCE_CNT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .row_in    (row_in),
        .col_drive (col_drive),
        .key_if    (key_if)
    );

    always #5 clk = ~clk;

    // Keypad model: the pressed key pulls its row(s) low only while its
    // column is strobed.
    logic       key_down  = 1'b0;
    logic [3:0] key_col_n = 4'b1111;
    logic [3:0] key_rows  = 4'b1111;
    assign row_in = (key_down && col_drive == key_col_n) ? key_rows : 4'b1111;

    exp_t exp_q[$];
    int   n_checks    = 0;
    int   n_fail      = 0;
    int   valid_count = 0;
    logic prev_valid  = 1'b0;

    // Monitor: pops the scoreboard on every key_valid strobe.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (key_if.key_valid === 1'b1) begin
            valid_count++;
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_key_valid: got c=%b r=%b code=%b, required no pulse",
                         key_if.c, key_if.r, key_if.key_code);
            end else begin
                e = exp_q.pop_front();
                if (key_if.c !== e.c || key_if.r !== e.r || key_if.key_code !== e.code) begin
                    n_fail++;
                    $display("FAIL key_accept: got c=%b r=%b code=%b, required c=%b r=%b code=%b",
                             key_if.c, key_if.r, key_if.key_code, e.c, e.r, e.code);
                end else begin
                    $display("key accepted: c=%b r=%b code=%b", key_if.c, key_if.r, key_if.key_code);
                end
            end
            if (prev_valid === 1'b1) begin
                n_checks++;
                n_fail++;
                $display("FAIL key_valid_width: got 2+ cycle pulse, required 1 cycle");
            end
        end
        prev_valid = key_if.key_valid;
    end

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %b, required %b", name, act, req);
        end
    endtask

    task automatic check_int(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    task automatic push_exp(input logic [3:0] c, input logic [3:0] r, input logic [3:0] code);
        exp_t e;
        e.c = c; e.r = r; e.code = code;
        exp_q.push_back(e);
    endtask

    task automatic press(input logic [3:0] col_n, input logic [3:0] rows);
        key_col_n = col_n;
        key_rows  = rows;
        key_down  = 1'b1;
    endtask

    task automatic wait_c_active(input string name, input int budget);
        int n = 0;
        while (key_if.c === 4'b1111 && n < budget) begin
            @(negedge clk);
            n++;
        end
        n_checks++;
        if (key_if.c === 4'b1111) begin
            n_fail++;
            $display("FAIL %s: got c=%b after %0d cycles, required accepted key", name, key_if.c, n);
        end
    endtask

    // Release the key and require c/r idle within the release bound,
    // with scanning restarting at the first column.
    task automatic release_key(input string name);
        int n = 0;
        key_down = 1'b0;
        while (key_if.c !== 4'b1111 && n < 40) begin
            @(negedge clk);
            n++;
        end
        n_checks++;
        if (key_if.c !== 4'b1111 || n > REL_MAX) begin
            n_fail++;
            $display("FAIL %s_release: got c=%b after %0d cycles, required 1111 within %0d",
                     name, key_if.c, n, REL_MAX);
        end
        check({name, "_release_r"}, key_if.r, 4'b1111);
        check({name, "_release_col"}, col_drive, 4'b1110);
        $display("%s released after %0d cycles", name, n);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got no end of test, required finish within 200 us");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        logic [3:0] scan_seq [4];
        logic [3:0] prev_col;
        int base;
        int changes;
        scan_seq[0] = 4'b1110; scan_seq[1] = 4'b1101;
        scan_seq[2] = 4'b1011; scan_seq[3] = 4'b0111;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_col_drive", col_drive, 4'b1110);
        check("rst_c", key_if.c, 4'b1111);
        check("rst_r", key_if.r, 4'b1111);
        check("rst_key_code", key_if.key_code, 4'b0000);
        check("rst_key_valid", {3'b000, key_if.key_valid}, 4'b0000);
        $display("reset state checked");

        // 1: idle scan, column advances every SCAN_DIV cycles
        reset = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            check("t1_scan_col", col_drive, scan_seq[(k / 4) % 4]);
        end
        check("t1_c_idle", key_if.c, 4'b1111);
        check("t1_r_idle", key_if.r, 4'b1111);
        check_int("t1_no_valid", valid_count, 0);
        $display("t1 idle scan done");

        // 2: col0/row0
        push_exp(4'b1110, 4'b1110, 4'b0000);
        press(4'b1110, 4'b1110);
        wait_c_active("t2_press", 100);
        for (int k = 0; k < 4; k++) begin
            repeat (3) @(negedge clk);
            check("t2_col_frozen", col_drive, 4'b1110);
        end
        check("t2_c_level", key_if.c, 4'b1110);
        release_key("t2");

        // 3: col2/row1, then release
        push_exp(4'b1011, 4'b1101, 4'b1001);
        press(4'b1011, 4'b1101);
        wait_c_active("t3_press", 100);
        repeat (6) @(negedge clk);
        check("t3_col_frozen", col_drive, 4'b1011);
        check("t3_r_level", key_if.r, 4'b1101);
        release_key("t3");

        // 4: bounce on col0/row2: 2 good ticks, 1 bad tick, then stable
        key_col_n = 4'b1110;
        key_rows  = 4'b1011;
        base = valid_count;
        begin
            int n = 0;
            while (col_drive === 4'b1110 && n < 40) begin @(negedge clk); n++; end
            while (col_drive !== 4'b1110 && n < 40) begin @(negedge clk); n++; end
            check("t4_sync_col", col_drive, 4'b1110);
        end
        push_exp(4'b1110, 4'b1011, 4'b0010);
        key_down = 1'b1;
        repeat (2 * SCAN_DIV) @(negedge clk);
        key_down = 1'b0;
        repeat (SCAN_DIV) @(negedge clk);
        check_int("t4_no_early_valid", valid_count, base);
        check("t4_rescan_col", col_drive, 4'b1101);
        key_down = 1'b1;
        wait_c_active("t4_press", 100);
        repeat (4) @(negedge clk);
        check_int("t4_single_pulse", valid_count, base + 1);
        release_key("t4");

        // 5: two rows low on col1 -> ignored, scanning keeps going
        base = valid_count;
        press(4'b1101, 4'b1100);
        prev_col = col_drive;
        changes  = 0;
        for (int k = 0; k < 12 * SCAN_DIV; k++) begin
            @(negedge clk);
            if (col_drive !== prev_col) changes++;
            prev_col = col_drive;
        end
        check_int("t5_col_changes", changes, 12);
        check("t5_c_idle", key_if.c, 4'b1111);
        check("t5_r_idle", key_if.r, 4'b1111);
        check_int("t5_no_valid", valid_count, base);
        key_down = 1'b0;
        repeat (4) @(negedge clk);
        $display("t5 ghost press ignored");

        // 6: async reset while HELD, key stays down through reset
        push_exp(4'b0111, 4'b0111, 4'b1111);
        press(4'b0111, 4'b0111);
        wait_c_active("t6_press", 100);
        repeat (2) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("t6_async_c", key_if.c, 4'b1111);
        check("t6_async_r", key_if.r, 4'b1111);
        check("t6_async_col", col_drive, 4'b1110);
        check("t6_async_valid", {3'b000, key_if.key_valid}, 4'b0000);
        repeat (3) @(negedge clk);
        base = valid_count;
        push_exp(4'b0111, 4'b0111, 4'b1111);
        reset = 1'b1;
        repeat (20) @(negedge clk);
        check_int("t6_no_early_valid", valid_count, base);
        wait_c_active("t6_repress", 100);
        repeat (2) @(negedge clk);
        check_int("t6_one_valid", valid_count, base + 1);
        release_key("t6");

        repeat (10) @(negedge clk);
        check_int("sb_queue_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
